// File: rtl/sb_spi_slave.sv
// Slave-only soft model of the iCE40 SB_SPI block: a byte-wide strobe/ack
// system bus in front of a serial SPI slave engine with status flags.
//
// state    | meaning
// BUS_IDLE | waiting for a strobe addressed to this instance
// BUS_ACK  | acknowledging the access accepted on the previous edge
module sb_spi_slave #(
  parameter logic [3:0] BUS_ADDR74 = 4'b0000
) (
  input  logic SBCLKI,
  input  logic rst_n,
  input  logic SBSTBI,
  input  logic SBRWI,
  input  logic SBADRI0,
  input  logic SBADRI1,
  input  logic SBADRI2,
  input  logic SBADRI3,
  input  logic SBADRI4,
  input  logic SBADRI5,
  input  logic SBADRI6,
  input  logic SBADRI7,
  input  logic SBDATI0,
  input  logic SBDATI1,
  input  logic SBDATI2,
  input  logic SBDATI3,
  input  logic SBDATI4,
  input  logic SBDATI5,
  input  logic SBDATI6,
  input  logic SBDATI7,
  output logic SBDATO0,
  output logic SBDATO1,
  output logic SBDATO2,
  output logic SBDATO3,
  output logic SBDATO4,
  output logic SBDATO5,
  output logic SBDATO6,
  output logic SBDATO7,
  output logic SBACKO,
  input  logic SCKI,
  input  logic SCSNI,
  input  logic SI,
  output logic SO,
  input  logic MI,
  output logic MO
);

  localparam logic [3:0] A_CR0  = 4'h8;
  localparam logic [3:0] A_CR1  = 4'h9;
  localparam logic [3:0] A_CR2  = 4'hA;
  localparam logic [3:0] A_BR   = 4'hB;
  localparam logic [3:0] A_SR   = 4'hC;
  localparam logic [3:0] A_TXDR = 4'hD;
  localparam logic [3:0] A_RXDR = 4'hE;
  localparam logic [3:0] A_CSR  = 4'hF;

  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_t;

  bus_state_t bus_state;
  logic       ack_q;
  logic [7:0] dato_q;
  logic [7:0] adr, dati, rd_mux, sr_val;
  logic [7:0] cr0, cr1, cr2, br, csr, txdr, rxdr;
  logic       hit, accept, wr_acc, rd_acc, sr_rd, rxdr_rd, txdr_wr;

  logic       sck_m, sck_s, sck_d, cs_m, cs_s, si_m, si_s;
  logic       active, active_d, sck_rise, sck_fall;
  logic       sample_ev, shift_ev, byte_done, load_ev;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh, rx_sh, rx_next;
  logic       trdy, rrdy, roe, toe;
  logic       spe, lsbf, cpha, cpol;
  logic       mi_unused;

  assign adr  = {SBADRI7, SBADRI6, SBADRI5, SBADRI4, SBADRI3, SBADRI2, SBADRI1, SBADRI0};
  assign dati = {SBDATI7, SBDATI6, SBDATI5, SBDATI4, SBDATI3, SBDATI2, SBDATI1, SBDATI0};
  assign {SBDATO7, SBDATO6, SBDATO5, SBDATO4, SBDATO3, SBDATO2, SBDATO1, SBDATO0} = dato_q;
  assign SBACKO    = ack_q;
  assign MO        = 1'b0;
  assign mi_unused = MI;

  assign hit     = (adr[7:4] == BUS_ADDR74);
  assign accept  = SBSTBI && hit && (bus_state == BUS_IDLE);
  assign wr_acc  = accept && SBRWI;
  assign rd_acc  = accept && !SBRWI;
  assign sr_rd   = rd_acc && (adr[3:0] == A_SR);
  assign rxdr_rd = rd_acc && (adr[3:0] == A_RXDR);
  assign txdr_wr = wr_acc && (adr[3:0] == A_TXDR);

  assign spe  = cr1[7];
  assign lsbf = cr2[0];
  assign cpha = cr2[1];
  assign cpol = cr2[2];

  assign sr_val = {(bit_cnt != 3'd0), !cs_s, 1'b0, trdy, rrdy, toe, roe, 1'b0};

  always_comb begin
    rd_mux = 8'h00;
    case (adr[3:0])
      A_CR0:   rd_mux = cr0;
      A_CR1:   rd_mux = cr1;
      A_CR2:   rd_mux = cr2;
      A_BR:    rd_mux = br;
      A_CSR:   rd_mux = csr;
      A_SR:    rd_mux = sr_val;
      A_RXDR:  rd_mux = rxdr;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge SBCLKI or negedge rst_n) begin
    if (!rst_n) begin
      bus_state <= BUS_IDLE;
      ack_q     <= 1'b0;
      dato_q    <= 8'h00;
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          if (accept) begin
            bus_state <= BUS_ACK;
            ack_q     <= 1'b1;
            if (!SBRWI) dato_q <= rd_mux;
          end
        end
        BUS_ACK: begin
          bus_state <= BUS_IDLE;
          ack_q     <= 1'b0;
        end
        default: begin
          bus_state <= BUS_IDLE;
          ack_q     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge SBCLKI or negedge rst_n) begin
    if (!rst_n) begin
      cr0  <= 8'h00;
      cr1  <= 8'h00;
      cr2  <= 8'h00;
      br   <= 8'h00;
      csr  <= 8'h00;
      txdr <= 8'h00;
    end else if (wr_acc) begin
      case (adr[3:0])
        A_CR0:   cr0  <= dati;
        A_CR1:   cr1  <= dati;
        A_CR2:   cr2  <= dati;
        A_BR:    br   <= dati;
        A_CSR:   csr  <= dati;
        A_TXDR:  txdr <= dati;
        default: ;
      endcase
    end
  end

  // Shifting is suppressed while bit_cnt is 0 so the freshly loaded first bit
  // stays on SO until the first sample of the byte, in every mode.
  assign active    = spe && !cs_s;
  assign sck_rise  = sck_s && !sck_d;
  assign sck_fall  = !sck_s && sck_d;
  assign sample_ev = active && ((cpol == cpha) ? sck_rise : sck_fall);
  assign shift_ev  = active && ((cpol == cpha) ? sck_fall : sck_rise) && (bit_cnt != 3'd0);
  assign byte_done = sample_ev && (bit_cnt == 3'd7);
  assign load_ev   = (active && !active_d) || byte_done;
  assign rx_next   = lsbf ? {si_s, rx_sh[7:1]} : {rx_sh[6:0], si_s};
  assign SO        = active && (lsbf ? tx_sh[0] : tx_sh[7]);

  always_ff @(posedge SBCLKI or negedge rst_n) begin
    if (!rst_n) begin
      sck_m    <= 1'b0;
      sck_s    <= 1'b0;
      sck_d    <= 1'b0;
      cs_m     <= 1'b1;
      cs_s     <= 1'b1;
      si_m     <= 1'b0;
      si_s     <= 1'b0;
      active_d <= 1'b0;
      bit_cnt  <= 3'd0;
      tx_sh    <= 8'h00;
      rx_sh    <= 8'h00;
      rxdr     <= 8'h00;
      trdy     <= 1'b1;
      rrdy     <= 1'b0;
      roe      <= 1'b0;
      toe      <= 1'b0;
    end else begin
      sck_m    <= SCKI;
      sck_s    <= sck_m;
      sck_d    <= sck_s;
      cs_m     <= SCSNI;
      cs_s     <= cs_m;
      si_m     <= SI;
      si_s     <= si_m;
      active_d <= active;

      if (!active) begin
        bit_cnt <= 3'd0;
        if (!spe) begin
          tx_sh <= 8'h00;
          rx_sh <= 8'h00;
        end
      end else begin
        if (sample_ev) begin
          rx_sh   <= rx_next;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (shift_ev) tx_sh <= lsbf ? (tx_sh >> 1) : (tx_sh << 1);
        if (load_ev)  tx_sh <= trdy ? 8'h00 : txdr;
      end

      if (sr_rd) begin
        roe <= 1'b0;
        toe <= 1'b0;
      end
      if (rxdr_rd) rrdy <= 1'b0;

      // A byte load sees the pre-write TRDY; a same-cycle TXDR write wins.
      if (load_ev) begin
        if (!trdy) trdy <= 1'b1;
        else       toe  <= 1'b1;
      end
      if (txdr_wr) trdy <= 1'b0;

      if (byte_done) begin
        rxdr <= rx_next;
        rrdy <= 1'b1;
        if (rrdy && !rxdr_rd) roe <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sb_spi_slave.sv
// Directed bench for sb_spi_slave: bus register access, status flags and
// serial transfers driven by a behavioural SPI master.
module tb_sb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stb = 1'b0;
  logic       rwi = 1'b0;
  logic [7:0] adr = 8'h00;
  logic [7:0] dati = 8'h00;
  wire  [7:0] dato;
  wire        ack;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       si = 1'b0;
  wire        so;
  logic       mi = 1'b0;
  wire        mo;

  int compared = 0;
  int mismatched = 0;
  int ack_cnt = 0;

  sb_spi_slave #(.BUS_ADDR74(4'b0000)) dut (
    .SBCLKI(clk), .rst_n(rst_n), .SBSTBI(stb), .SBRWI(rwi),
    .SBADRI0(adr[0]), .SBADRI1(adr[1]), .SBADRI2(adr[2]), .SBADRI3(adr[3]),
    .SBADRI4(adr[4]), .SBADRI5(adr[5]), .SBADRI6(adr[6]), .SBADRI7(adr[7]),
    .SBDATI0(dati[0]), .SBDATI1(dati[1]), .SBDATI2(dati[2]), .SBDATI3(dati[3]),
    .SBDATI4(dati[4]), .SBDATI5(dati[5]), .SBDATI6(dati[6]), .SBDATI7(dati[7]),
    .SBDATO0(dato[0]), .SBDATO1(dato[1]), .SBDATO2(dato[2]), .SBDATO3(dato[3]),
    .SBDATO4(dato[4]), .SBDATO5(dato[5]), .SBDATO6(dato[6]), .SBDATO7(dato[7]),
    .SBACKO(ack), .SCKI(sck), .SCSNI(csn), .SI(si), .SO(so), .MI(mi), .MO(mo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ack === 1'b1) ack_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe stays high through the ack cycle to show it is not re-accepted.
  task automatic bus(input logic rw, input logic [7:0] a, input logic [7:0] wd,
                     output logic [7:0] rd, output int lat, output logic ack_after);
    @(negedge clk);
    stb = 1'b1; rwi = rw; adr = a; dati = wd;
    lat = 0; rd = 8'h00; ack_after = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        lat = i;
        rd  = dato;
        break;
      end
    end
    if (lat != 0) begin
      @(posedge clk); #1;
      ack_after = ack;
    end
    @(negedge clk);
    stb = 1'b0; rwi = 1'b0;
  endtask

  task automatic rd_reg(input string tag, input logic [7:0] a, input logic [7:0] mask,
                        input logic [7:0] exp);
    logic [7:0] rd;
    int         lat;
    logic       aa;
    bus(1'b0, a, 8'h00, rd, lat, aa);
    check({tag, "_lat"}, lat, 1);
    check({tag, "_ack1cyc"}, {31'd0, aa}, 0);
    check(tag, {24'd0, rd & mask}, {24'd0, exp});
  endtask

  task automatic wr_reg(input string tag, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rd;
    int         lat;
    logic       aa;
    bus(1'b1, a, d, rd, lat, aa);
    check({tag, "_lat"}, lat, 1);
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    csn = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    csn = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] mosi, input logic lsbf, input logic cpol,
                          input logic cpha, output logic [7:0] miso);
    int idx;
    miso = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = lsbf ? i : 7 - i;
      if (!cpha) begin
        si = mosi[idx];
        half();
        miso[idx] = so;
        sck = ~cpol;
        half();
        sck = cpol;
      end else begin
        sck = ~cpol;
        si = mosi[idx];
        half();
        miso[idx] = so;
        sck = cpol;
        half();
      end
    end
  endtask

  initial begin
    logic [7:0] miso, rd, hold;
    int         c0, lat;
    logic       aa;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_dato", {24'd0, dato}, 0);
    check("rst_so", {31'd0, so}, 0);
    check("rst_mo", {31'd0, mo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset status and single-ack behaviour
    c0 = ack_cnt;
    rd_reg("sr_reset", 8'h0C, 8'hFF, 8'h10);
    check("sr_reset_acks", ack_cnt - c0, 1);

    c0 = ack_cnt;
    wr_reg("cr1_wr", 8'h09, 8'h80);
    check("cr1_wr_acks", ack_cnt - c0, 1);
    rd_reg("cr1_rd", 8'h09, 8'hFF, 8'h80);

    // Mode 0, LSB first receive
    wr_reg("cr2_wr", 8'h0A, 8'h01);
    rd_reg("cr2_rd", 8'h0A, 8'hFF, 8'h01);
    cs_low();
    spi_byte(8'h11, 1'b1, 1'b0, 1'b0, miso);
    cs_high();
    check("so_idle", {31'd0, so}, 0);
    rd_reg("sr_rx11", 8'h0C, 8'hFF, 8'h1C);
    rd_reg("rxdr_11", 8'h0E, 8'hFF, 8'h11);
    rd_reg("sr_after_rx", 8'h0C, 8'hFF, 8'h10);

    // Transmit 0x41 LSB first, then an underrun byte
    wr_reg("txdr_wr", 8'h0D, 8'h41);
    rd_reg("sr_trdy0", 8'h0C, 8'hFF, 8'h00);
    rd_reg("txdr_rd0", 8'h0D, 8'hFF, 8'h00);
    cs_low();
    spi_byte(8'h5A, 1'b1, 1'b0, 1'b0, miso);
    check("miso_41", {24'd0, miso}, 32'h41);
    rd_reg("sr_trdy1", 8'h0C, 8'h10, 8'h10);
    rd_reg("rxdr_5a", 8'h0E, 8'hFF, 8'h5A);
    spi_byte(8'h00, 1'b1, 1'b0, 1'b0, miso);
    check("miso_under", {24'd0, miso}, 32'h00);
    cs_high();
    rd_reg("sr_toe", 8'h0C, 8'hFF, 8'h1C);
    rd_reg("rxdr_00", 8'h0E, 8'hFF, 8'h00);

    // Overrun: two bytes without reading RXDR
    cs_low();
    spi_byte(8'hA5, 1'b1, 1'b0, 1'b0, miso);
    spi_byte(8'h3C, 1'b1, 1'b0, 1'b0, miso);
    cs_high();
    rd_reg("sr_roe", 8'h0C, 8'hFF, 8'h1E);
    rd_reg("sr_roe_clr", 8'h0C, 8'hFF, 8'h18);
    rd_reg("rxdr_3c", 8'h0E, 8'hFF, 8'h3C);

    // Mode 3, MSB first, full duplex
    @(negedge clk);
    sck = 1'b1;
    repeat (6) @(negedge clk);
    wr_reg("cr2_m3", 8'h0A, 8'h06);
    wr_reg("txdr_96", 8'h0D, 8'h96);
    cs_low();
    spi_byte(8'hC3, 1'b0, 1'b1, 1'b1, miso);
    check("miso_96", {24'd0, miso}, 32'h96);
    cs_high();
    rd_reg("sr_m3", 8'h0C, 8'hFF, 8'h1C);
    rd_reg("rxdr_c3", 8'h0E, 8'hFF, 8'h C3);

    // Foreign upper nibble: no ack, no effect
    hold = dato;
    c0 = ack_cnt;
    bus(1'b0, 8'h1C, 8'h00, rd, lat, aa);
    check("foreign_rd_lat", lat, 0);
    check("foreign_rd_dato", {24'd0, dato}, {24'd0, hold});
    bus(1'b1, 8'h18, 8'hFF, rd, lat, aa);
    check("foreign_wr_lat", lat, 0);
    check("foreign_acks", ack_cnt - c0, 0);
    rd_reg("cr0_untouched", 8'h08, 8'hFF, 8'h00);
    rd_reg("sr_final", 8'h0C, 8'hFF, 8'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sb_spi_slave.md
# sb_spi_slave

Soft model of the iCE40 hard SPI block (SB_SPI), slave-only. It translates a byte-wide strobe/ack system bus into a serial SPI slave port. Fabric logic uses it to configure the SPI engine, poll status, read received bytes and queue bytes for transmission to an external master.

## Interface
- BUS_ADDR74, 4'b0000: upper address nibble this instance answers to (SBADRI[7:4]).
- SBCLKI  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- SBSTBI  in  1  bus strobe; high requests an access.
- SBRWI  in  1  1 = write, 0 = read.
- SBADRI0..7  in  1 each  register address bits.
- SBDATI0..7  in  1 each  write data bits.
- SBDATO0..7  out  1 each  read data bits, registered.
- SBACKO  out  1  one-cycle access acknowledge.
- SCKI  in  1  SPI clock from the master.
- SCSNI  in  1  SPI chip select, active low.
- SI  in  1  slave input (MOSI).
- SO  out  1  slave output (MISO).
- MI  in  1  master input; ignored.
- MO  out  1  master output; constant 0.

## Operation
- Register map, selected by SBADRI[3:0] when SBADRI[7:4] == BUS_ADDR74:
  - 0x8 SPICR0: R/W, stored only.
  - 0x9 SPICR1: R/W; bit7 SPE enables the serial engine.
  - 0xA SPICR2: R/W; bit0 LSBF (1 = LSB first), bit1 CPHA, bit2 CPOL. Bit7 (MSTR) is stored but ignored; the block is always a slave.
  - 0xB SPIBR: R/W, stored only.
  - 0xF SPICSR: R/W, stored only.
  - 0xC SPISR: read-only. bit7 TIP (byte in progress), bit6 BUSY (SCSNI low), bit4 TRDY, bit3 RRDY, bit2 TOE, bit1 ROE. Other bits 0.
  - 0xD SPITXDR: write-only; reads return 0x00.
  - 0xE SPIRXDR: read-only.
- Reads of unmapped addresses return 0x00 and are acknowledged. Writes to read-only or unmapped addresses are ignored and acknowledged.
- Address with an upper nibble other than BUS_ADDR74: no ack, no side effects.
- Read side effects:
  - Reading SPIRXDR clears RRDY.
  - Reading SPISR clears ROE and TOE; the returned value shows them before clearing.
- Writing SPITXDR latches the byte and clears TRDY.
- Serial engine, active only when SPE=1 and SCSNI low:
  - SCKI, SCSNI and SI pass through 2-flop synchronizers; edges are detected in the SBCLKI domain.
  - Mode is set by CPOL/CPHA per standard SPI. Mode 0: sample SI on SCK rise, shift SO on SCK fall.
  - Bit order is set by LSBF and applies to both directions.
  - Byte load: at SCSNI fall and after each completed 8th sample, the TX shifter loads for the next byte.
    - If TRDY=0: load SPITXDR, then set TRDY=1.
    - Otherwise: load 0x00 and set TOE=1.
  - After 8 samples: SPIRXDR <= RX shifter and RRDY <= 1. If RRDY was already 1, set ROE=1; the new byte overwrites.
  - SCSNI rising mid-byte discards the partial byte and resets the bit counter.
- SO is 0 when SCSNI is high or SPE=0.
- SPE=0 holds the bit counter and shifters in reset. Register and status access still works.

## Timing
- A bus access is accepted on a cycle with SBSTBI=1 and SBACKO=0.
- On the next edge: SBACKO=1 for exactly one cycle. For reads, SBDATO is valid in that same cycle and holds until the next read.
- A strobe still high while SBACKO=1 is not a new access. A master holding SBSTBI high therefore sees one ack per transaction.
- Write data takes effect in the ack cycle.
- Serial latency is 2-3 SBCLKI cycles after an SCKI edge. SCKI must not exceed SBCLKI/4.
- A byte-completion event and a SPIRXDR read in the same cycle: the completion wins, so RRDY=1 and ROE is not set.
- A SPITXDR write in the same cycle as a byte load: the load uses the old state; the new byte stays pending with TRDY=0.
- Reset values:
  - Outputs: SBACKO=0, SBDATO=0x00, SO=0, MO=0.
  - Registers: all 0x00.
  - Status: TRDY=1; RRDY, ROE, TOE, TIP and BUSY all 0.
- Reset mid-transfer aborts the transfer immediately.

## Test plan
- Reset, then read SPISR (0x0C): returns 0x10. SBACKO pulses once, 1 cycle after acceptance.
- Write SPICR1=0x80 with the strobe held for 3 cycles, then read SPICR1: exactly one ack per transaction; readback 0x80.
- SPICR2=0x01, SPE=1; master sends 0x11 LSB first. Result: SPISR bit3=1, SPIRXDR read = 0x11, SPISR then shows RRDY=0.
- Write SPITXDR=0x41 (SPISR bit4 becomes 0); master clocks a byte in mode 0 with LSBF=1. SO shifts out 1,0,0,0,0,0,1,0 and TRDY returns to 1. The next byte, with no write, sends 0x00 and sets TOE.
- Master sends 0xA5 then 0x3C with no RXDR read. Result: SPIRXDR = 0x3C, ROE=1; reading SPISR returns bit1=1, and a second read returns bit1=0.
- Access address 0x1C with BUS_ADDR74=0: no ack within 10 cycles, no state change.
